// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: skid-buffer state encoding, default bubble control word,
// and per-stage control widths/bit positions used when packing stage control payloads.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // All-zero control word: no RegWrite, no MemWrite, no branch.
    localparam logic [31:0] CTRL_BUBBLE_DEFAULT = 32'h0;

    localparam int IDEX_CTRL_W  = 16;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_CTRL_W = 4;

    localparam int IDEX_ALU_OP_LSB     = 0;
    localparam int IDEX_ALU_OP_W       = 4;
    localparam int IDEX_ALU_SRC_BIT    = 4;
    localparam int IDEX_BRANCH_BIT     = 5;
    localparam int IDEX_JUMP_BIT       = 6;
    localparam int IDEX_MEM_READ_BIT   = 7;
    localparam int IDEX_MEM_WRITE_BIT  = 8;
    localparam int IDEX_MEM_SIZE_LSB   = 9;
    localparam int IDEX_MEM_SIZE_W     = 2;
    localparam int IDEX_REG_WRITE_BIT  = 11;
    localparam int IDEX_MEM_TO_REG_BIT = 12;

    localparam int EXMEM_MEM_READ_BIT   = 0;
    localparam int EXMEM_MEM_WRITE_BIT  = 1;
    localparam int EXMEM_MEM_SIZE_LSB   = 2;
    localparam int EXMEM_MEM_SIZE_W     = 2;
    localparam int EXMEM_REG_WRITE_BIT  = 4;
    localparam int EXMEM_MEM_TO_REG_BIT = 5;

    localparam int MEMWB_REG_WRITE_BIT  = 0;
    localparam int MEMWB_MEM_TO_REG_BIT = 1;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer (head + skid register) with a registered ready, so the upstream
// ready never depends combinationally on the downstream ready.
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] in_pay,
    output logic         in_ready,
    output logic         head_valid,
    output logic [W-1:0] head_pay,
    output logic [1:0]   occupancy
);

    skid_state_e  state_q, state_d;
    logic         in_ready_q;
    logic [W-1:0] head_q, skid_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (push) state_d = ST_ONE;
                ST_ONE: begin
                    if (push && !pop)      state_d = ST_FULL;
                    else if (pop && !push) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // NOTE: payload storage is reset because a cleared head/skid is part of the visible reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state_q)
                ST_EMPTY: if (push) head_q <= in_pay;
                ST_ONE: begin
                    if (push && pop) head_q <= in_pay;
                    else if (push)   skid_q <= in_pay;
                end
                ST_FULL:  if (pop) head_q <= skid_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        head_valid = (state_q != ST_EMPTY);
        head_pay   = head_q;
        occupancy  = state_q;
        in_ready   = in_ready_q;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush-to-bubble and
// either a single head register (SKID=0) or a 2-entry skid buffer (SKID=1).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT),
    parameter int                SKID        = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [DATA_W-1:0] In_data,
    input  logic [CTRL_W-1:0] In_ctrl,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] Out_data,
    output logic [CTRL_W-1:0] Out_ctrl,
    output logic [1:0]        Occupancy
);

    localparam int PAY_W = DATA_W + CTRL_W;

    logic             head_valid;
    logic [PAY_W-1:0] head_pay;
    logic [1:0]       occ;
    logic             rdy;
    logic             push, pop;

    // A flushed cycle discards the incoming entry; a pop still counts downstream.
    assign push = In_valid && rdy && !Flush;
    assign pop  = head_valid && Out_ready;

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(.W(PAY_W)) u_skid (
                .clk       (Clk),
                .rst_n     (Rst_n),
                .flush     (Flush),
                .push      (push),
                .pop       (pop),
                .in_pay    ({In_data, In_ctrl}),
                .in_ready  (rdy),
                .head_valid(head_valid),
                .head_pay  (head_pay),
                .occupancy (occ)
            );
        end else begin : g_reg
            logic             valid_q;
            logic [PAY_W-1:0] pay_q;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    valid_q <= 1'b0;
                    pay_q   <= '0;
                end else if (Flush) begin
                    valid_q <= 1'b0;
                end else if (push) begin
                    valid_q <= 1'b1;
                    pay_q   <= {In_data, In_ctrl};
                end else if (pop) begin
                    valid_q <= 1'b0;
                end
            end

            assign rdy        = Out_ready || !valid_q;
            assign head_valid = valid_q;
            assign head_pay   = pay_q;
            assign occ        = {1'b0, valid_q};
        end
    endgenerate

    // Downstream must never act on a stale control word, so empty slots show the bubble.
    assign In_ready  = rdy;
    assign Out_valid = head_valid;
    assign Out_data  = head_pay[PAY_W-1:CTRL_W];
    assign Out_ctrl  = head_valid ? head_pay[CTRL_W-1:0] : CTRL_BUBBLE;
    assign Occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 instance with shared stimulus and compares both against
// queue-based models of an ordered buffer with capacity 2 and 1 respectively.
module tb_pipe_stage_reg;

    localparam logic [15:0] BUB_S = 16'h5A5A;
    localparam logic [15:0] BUB_R = 16'h0000;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;

    logic        s_in_ready, s_out_valid, r_in_ready, r_out_valid;
    logic [31:0] s_out_data, r_out_data;
    logic [15:0] s_out_ctrl, r_out_ctrl;
    logic [1:0]  s_occ, r_occ;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] ctrl;
    } entry_t;

    entry_t      q_s[$];
    entry_t      q_r[$];
    logic [31:0] last_s, last_r;
    int          n_checks, n_errs;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CTRL_BUBBLE(BUB_S), .SKID(1)) u_skid (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(flush),
        .In_valid(in_valid), .In_ready(s_in_ready), .In_data(in_data), .In_ctrl(in_ctrl),
        .Out_valid(s_out_valid), .Out_ready(out_ready), .Out_data(s_out_data),
        .Out_ctrl(s_out_ctrl), .Occupancy(s_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CTRL_BUBBLE(BUB_R), .SKID(0)) u_reg (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(flush),
        .In_valid(in_valid), .In_ready(r_in_ready), .In_data(in_data), .In_ctrl(in_ctrl),
        .Out_valid(r_out_valid), .Out_ready(out_ready), .Out_data(r_out_data),
        .Out_ctrl(r_out_ctrl), .Occupancy(r_occ)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(bit chk_rdy);
        logic [31:0] ed;
        logic [15:0] ec;
        // SKID=1: ordered buffer of two, registered ready = "not full after the edge"
        ed = last_s;
        ec = BUB_S;
        if (q_s.size() > 0) begin
            ed = q_s[0].data;
            ec = q_s[0].ctrl;
        end
        if (chk_rdy) check("skid in_ready", 64'(s_in_ready), 64'(q_s.size() < 2));
        check("skid out_valid", 64'(s_out_valid), 64'(q_s.size() > 0));
        check("skid out_data", 64'(s_out_data), 64'(ed));
        check("skid out_ctrl", 64'(s_out_ctrl), 64'(ec));
        check("skid occupancy", 64'(s_occ), 64'(q_s.size()));
        // SKID=0: single slot, ready whenever it is empty or being drained
        ed = last_r;
        ec = BUB_R;
        if (q_r.size() > 0) begin
            ed = q_r[0].data;
            ec = q_r[0].ctrl;
        end
        if (chk_rdy) check("reg in_ready", 64'(r_in_ready), 64'(out_ready || q_r.size() == 0));
        check("reg out_valid", 64'(r_out_valid), 64'(q_r.size() > 0));
        check("reg out_data", 64'(r_out_data), 64'(ed));
        check("reg out_ctrl", 64'(r_out_ctrl), 64'(ec));
        check("reg occupancy", 64'(r_occ), 64'(q_r.size()));
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic tick();
        bit     push_s, pop_s, push_r, pop_r;
        entry_t e;
        #1;
        check_all(1'b1);
        e      = {in_data, in_ctrl};
        push_s = in_valid && (q_s.size() < 2) && !flush;
        pop_s  = (q_s.size() > 0) && out_ready;
        push_r = in_valid && (out_ready || q_r.size() == 0) && !flush;
        pop_r  = (q_r.size() > 0) && out_ready;
        @(posedge Clk);
        if (flush) begin
            q_s.delete();
            q_r.delete();
        end else begin
            if (pop_s)  void'(q_s.pop_front());
            if (push_s) q_s.push_back(e);
            if (pop_r)  void'(q_r.pop_front());
            if (push_r) q_r.push_back(e);
        end
        if (q_s.size() > 0) last_s = q_s[0].data;
        if (q_r.size() > 0) last_r = q_r[0].data;
        @(negedge Clk);
    endtask

    task automatic drive(bit v, logic [31:0] d, bit ordy, bit fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = 16'($urandom_range(1, 16'hFFFF));
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        n_checks  = 0;
        n_errs    = 0;
        last_s    = '0;
        last_r    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset and idle
        repeat (2) @(negedge Clk);
        #1 check_all(1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        drive(0, 32'h0, 1, 0); tick(); tick();

        // Streaming at full throughput
        drive(1, 32'h20, 1, 0); tick();
        drive(1, 32'h21, 1, 0); tick();
        drive(1, 32'h22, 1, 0); tick();
        drive(0, 32'h0, 1, 0);  tick(); tick();

        // Stall fills the skid buffer, then drain in order
        drive(1, 32'hA0, 0, 0); tick();
        drive(1, 32'hB0, 0, 0); tick();
        drive(0, 32'h0, 0, 0);  tick(); tick();
        drive(0, 32'h0, 1, 0);  tick(); tick(); tick();

        // Flush while full, with a push presented in the same cycle
        drive(1, 32'hA0, 0, 0); tick();
        drive(1, 32'hB0, 0, 0); tick();
        drive(1, 32'hC0, 0, 1); tick();
        drive(0, 32'h0, 1, 0);  tick(); tick();

        // Asynchronous reset while stalled and full
        drive(1, 32'hA0, 0, 0); tick();
        drive(1, 32'hB0, 0, 0); tick();
        drive(0, 32'h0, 0, 0);  tick();
        #2 Rst_n = 1'b0;
        #1;
        q_s.delete();
        q_r.delete();
        last_s = '0;
        last_r = '0;
        check_all(1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        drive(0, 32'h0, 1, 0); tick();

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
            tick();
        end
        drive(0, 32'h0, 1, 0); tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
